// File: rtl/sram_arbiter_if.sv
// Request/response and shared-memory signals between the two CPU requesters,
// the arbiter and the single-port SRAM. The slave view is the arbiter; the master view is its environment.
interface sram_arbiter_if;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;

   logic        data_req;
   logic        data_wr;
   logic [3:0]  data_wstrb;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;

   logic        mem_en;
   logic [3:0]  mem_wen;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   modport slave (
      input  inst_req, inst_addr,
      input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
      input  mem_rdata,
      output inst_addr_ok, inst_data_ok, inst_rdata,
      output data_addr_ok, data_data_ok, data_rdata,
      output mem_en, mem_wen, mem_addr, mem_wdata
   );

   modport master (
      output inst_req, inst_addr,
      output data_req, data_wr, data_wstrb, data_addr, data_wdata,
      output mem_rdata,
      input  inst_addr_ok, inst_data_ok, inst_rdata,
      input  data_addr_ok, data_data_ok, data_rdata,
      input  mem_en, mem_wen, mem_addr, mem_wdata
   );
endinterface

// File: rtl/sram_arbiter.sv
// Shares one single-port synchronous SRAM between the instruction and data requesters,
// data-first with a starvation escape for instruction fetch, returning responses by owner tag.
module sram_arbiter #(
   parameter int MEM_LAT    = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic          clk,
   input  logic          resetn,
   sram_arbiter_if.slave bus
);

   localparam int CNT_W = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

   logic [CNT_W-1:0]   starve_cnt;
   logic [MEM_LAT-1:0] vld_p;
   logic [MEM_LAT-1:0] is_data_p;
   logic               grant_inst;
   logic               grant_data;

   // Grant is gated by resetn so nothing is accepted while reset is being sampled.
   always_comb begin
      grant_inst = 1'b0;
      grant_data = 1'b0;
      if (resetn) begin
         if (bus.data_req && !(bus.inst_req && starve_cnt == CNT_MAX))
            grant_data = 1'b1;
         else if (bus.inst_req)
            grant_inst = 1'b1;
      end
   end

   assign bus.inst_addr_ok = grant_inst;
   assign bus.data_addr_ok = grant_data;
   assign bus.mem_en       = grant_inst | grant_data;
   assign bus.mem_addr     = grant_data ? bus.data_addr : bus.inst_addr;
   assign bus.mem_wen      = (grant_data && bus.data_wr) ? bus.data_wstrb : 4'b0000;
   assign bus.mem_wdata    = bus.data_wdata;

   // Owner pipeline stage 0 is loaded with the grant; the last stage is the response slot.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         vld_p      <= '0;
         starve_cnt <= '0;
      end else begin
         vld_p[0] <= grant_inst | grant_data;
         for (int i = 1; i < MEM_LAT; i++)
            vld_p[i] <= vld_p[i-1];
         if (!bus.inst_req || grant_inst)
            starve_cnt <= '0;
         else if (grant_data && starve_cnt != CNT_MAX)
            starve_cnt <= starve_cnt + 1'b1;
      end
   end

   // Owner tag is only meaningful alongside its valid bit, so it carries no reset.
   always_ff @(posedge clk) begin
      is_data_p[0] <= grant_data;
      for (int i = 1; i < MEM_LAT; i++)
         is_data_p[i] <= is_data_p[i-1];
   end

   assign bus.inst_data_ok = vld_p[MEM_LAT-1] & ~is_data_p[MEM_LAT-1];
   assign bus.data_data_ok = vld_p[MEM_LAT-1] &  is_data_p[MEM_LAT-1];
   assign bus.inst_rdata   = bus.mem_rdata;
   assign bus.data_rdata   = bus.mem_rdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: one instance at MEM_LAT=1 and one at MEM_LAT=3,
// sharing clock and reset, each driven through its own interface.
module tb_sram_arbiter;

   logic clk;
   logic resetn;
   int   total;
   int   bad;

   sram_arbiter_if if1 ();
   sram_arbiter_if if3 ();

   sram_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) dut1 (.clk(clk), .resetn(resetn), .bus(if1.slave));
   sram_arbiter #(.MEM_LAT(3), .STARVE_MAX(4)) dut3 (.clk(clk), .resetn(resetn), .bus(if3.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      if1.inst_req = 1'b0; if1.data_req = 1'b0; if1.data_wr = 1'b0; if1.data_wstrb = 4'b0000;
      if3.inst_req = 1'b0; if3.data_req = 1'b0; if3.data_wr = 1'b0; if3.data_wstrb = 4'b0000;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      if1.inst_req = 1'b1; if1.data_req = 1'b1;
      if3.inst_req = 1'b1; if3.data_req = 1'b1;
      tick();
      tick();
      #1;
      total++;
      if ({if1.inst_addr_ok, if1.data_addr_ok, if1.inst_data_ok, if1.data_data_ok, if1.mem_en, if1.mem_wen} !== 9'b0) begin
         bad++; $display("FAIL reset_outputs_lat1 got=%b exp=0", {if1.inst_addr_ok, if1.data_addr_ok, if1.inst_data_ok, if1.data_data_ok, if1.mem_en, if1.mem_wen});
      end
      total++;
      if ({if3.inst_addr_ok, if3.data_addr_ok, if3.inst_data_ok, if3.data_data_ok, if3.mem_en, if3.mem_wen} !== 9'b0) begin
         bad++; $display("FAIL reset_outputs_lat3 got=%b exp=0", {if3.inst_addr_ok, if3.data_addr_ok, if3.inst_data_ok, if3.data_data_ok, if3.mem_en, if3.mem_wen});
      end
      resetn = 1'b1;
      #1;
      total++;
      if ({if1.data_addr_ok, if1.inst_addr_ok} !== 2'b10) begin
         bad++; $display("FAIL reset_first_grant got=%b exp=10", {if1.data_addr_ok, if1.inst_addr_ok});
      end
      idle();
      tick();
      tick();
   endtask

   task automatic test_inst_read();
      if1.inst_req  = 1'b1;
      if1.inst_addr = 32'h1c00_0000;
      #1;
      total++;
      if ({if1.inst_addr_ok, if1.mem_en, if1.mem_wen} !== 6'b110000) begin
         bad++; $display("FAIL inst_read_grant got=%b exp=110000", {if1.inst_addr_ok, if1.mem_en, if1.mem_wen});
      end
      total++;
      if (if1.mem_addr !== 32'h1c00_0000) begin
         bad++; $display("FAIL inst_read_mem_addr got=%h exp=1c000000", if1.mem_addr);
      end
      tick();
      if1.inst_req  = 1'b0;
      if1.mem_rdata = 32'h0280_0c0c;
      #1;
      total++;
      if ({if1.inst_data_ok, if1.data_data_ok} !== 2'b10) begin
         bad++; $display("FAIL inst_read_data_ok got=%b exp=10", {if1.inst_data_ok, if1.data_data_ok});
      end
      total++;
      if (if1.inst_rdata !== 32'h0280_0c0c) begin
         bad++; $display("FAIL inst_read_rdata got=%h exp=02800c0c", if1.inst_rdata);
      end
      tick();
      total++;
      if (if1.inst_data_ok !== 1'b0) begin
         bad++; $display("FAIL inst_read_ok_clears got=%b exp=0", if1.inst_data_ok);
      end
   endtask

   task automatic test_data_write();
      if1.data_req = 1'b1; if1.data_wr = 1'b1; if1.data_wstrb = 4'b0011;
      if1.data_addr = 32'h0000_1000; if1.data_wdata = 32'hdead_beef;
      if3.data_req = 1'b1; if3.data_wr = 1'b1; if3.data_wstrb = 4'b0011;
      if3.data_addr = 32'h0000_1000; if3.data_wdata = 32'hdead_beef;
      #1;
      total++;
      if ({if1.data_addr_ok, if1.mem_en, if1.mem_wen, if1.mem_addr, if1.mem_wdata} !== {2'b11, 4'b0011, 32'h1000, 32'hdead_beef}) begin
         bad++; $display("FAIL write_grant_lat1 got=%b/%b/%h/%h exp=11/0011/00001000/deadbeef", {if1.data_addr_ok, if1.mem_en}, if1.mem_wen, if1.mem_addr, if1.mem_wdata);
      end
      total++;
      if ({if3.data_addr_ok, if3.mem_wen, if3.mem_addr} !== {1'b1, 4'b0011, 32'h1000}) begin
         bad++; $display("FAIL write_grant_lat3 got=%b/%b/%h exp=1/0011/00001000", if3.data_addr_ok, if3.mem_wen, if3.mem_addr);
      end
      for (int k = 1; k <= 3; k++) begin
         tick();
         idle();
         #1;
         total++;
         if ({if1.data_data_ok, if1.inst_data_ok} !== {(k == 1), 1'b0}) begin
            bad++; $display("FAIL write_resp_lat1 cyc=%0d got=%b exp=%b", k, {if1.data_data_ok, if1.inst_data_ok}, {(k == 1), 1'b0});
         end
         total++;
         if ({if3.data_data_ok, if3.inst_data_ok} !== {(k == 3), 1'b0}) begin
            bad++; $display("FAIL write_resp_lat3 cyc=%0d got=%b exp=%b", k, {if3.data_data_ok, if3.inst_data_ok}, {(k == 3), 1'b0});
         end
      end
      tick();
   endtask

   task automatic test_starvation();
      logic exp_i, exp_ok_i, exp_ok_d;
      if1.inst_req = 1'b1; if1.inst_addr = 32'h1c00_0040;
      if1.data_req = 1'b1; if1.data_wr = 1'b0; if1.data_addr = 32'h0000_2000;
      for (int k = 0; k < 10; k++) begin
         exp_i    = (k % 5 == 4);
         exp_ok_i = (k > 0) && ((k - 1) % 5 == 4);
         exp_ok_d = (k > 0) && !exp_ok_i;
         #1;
         total++;
         if ({if1.inst_addr_ok, if1.data_addr_ok} !== {exp_i, ~exp_i}) begin
            bad++; $display("FAIL starve_grant cyc=%0d got=%b exp=%b", k, {if1.inst_addr_ok, if1.data_addr_ok}, {exp_i, ~exp_i});
         end
         total++;
         if (if1.mem_addr !== (exp_i ? 32'h1c00_0040 : 32'h0000_2000)) begin
            bad++; $display("FAIL starve_mem_addr cyc=%0d got=%h", k, if1.mem_addr);
         end
         total++;
         if ({if1.inst_data_ok, if1.data_data_ok} !== {exp_ok_i, exp_ok_d}) begin
            bad++; $display("FAIL starve_resp cyc=%0d got=%b exp=%b", k, {if1.inst_data_ok, if1.data_data_ok}, {exp_ok_i, exp_ok_d});
         end
         tick();
      end
      idle();
      tick();
   endtask

   task automatic test_pipeline();
      logic [31:0] rd [3];
      logic [1:0]  exp_ok [3];
      rd[0] = 32'h1111_0001; rd[1] = 32'h2222_0002; rd[2] = 32'h3333_0003;
      exp_ok[0] = 2'b10; exp_ok[1] = 2'b01; exp_ok[2] = 2'b10;
      if3.inst_req = 1'b1; if3.inst_addr = 32'h1c00_0100;
      #1;
      total++;
      if ({if3.inst_addr_ok, if3.data_addr_ok, if3.mem_addr} !== {2'b10, 32'h1c00_0100}) begin
         bad++; $display("FAIL pipe_grant0 got=%b/%h exp=10/1c000100", {if3.inst_addr_ok, if3.data_addr_ok}, if3.mem_addr);
      end
      tick();
      if3.inst_req = 1'b0;
      if3.data_req = 1'b1; if3.data_wr = 1'b0; if3.data_addr = 32'h0000_3000;
      #1;
      total++;
      if ({if3.inst_addr_ok, if3.data_addr_ok, if3.mem_wen, if3.mem_addr} !== {2'b01, 4'b0000, 32'h0000_3000}) begin
         bad++; $display("FAIL pipe_grant1 got=%b/%b/%h exp=01/0000/00003000", {if3.inst_addr_ok, if3.data_addr_ok}, if3.mem_wen, if3.mem_addr);
      end
      tick();
      if3.data_req = 1'b0;
      if3.inst_req = 1'b1; if3.inst_addr = 32'h1c00_0104;
      #1;
      total++;
      if ({if3.inst_addr_ok, if3.data_addr_ok, if3.inst_data_ok, if3.data_data_ok} !== 4'b1000) begin
         bad++; $display("FAIL pipe_grant2 got=%b exp=1000", {if3.inst_addr_ok, if3.data_addr_ok, if3.inst_data_ok, if3.data_data_ok});
      end
      tick();
      idle();
      for (int k = 0; k < 3; k++) begin
         if3.mem_rdata = rd[k];
         #1;
         total++;
         if ({if3.inst_data_ok, if3.data_data_ok} !== exp_ok[k]) begin
            bad++; $display("FAIL pipe_order cyc=%0d got=%b exp=%b", k + 3, {if3.inst_data_ok, if3.data_data_ok}, exp_ok[k]);
         end
         total++;
         if ((exp_ok[k][1] ? if3.inst_rdata : if3.data_rdata) !== rd[k]) begin
            bad++; $display("FAIL pipe_rdata cyc=%0d got=%h exp=%h", k + 3, exp_ok[k][1] ? if3.inst_rdata : if3.data_rdata, rd[k]);
         end
         tick();
      end
      #1;
      total++;
      if ({if3.inst_data_ok, if3.data_data_ok} !== 2'b00) begin
         bad++; $display("FAIL pipe_drained got=%b exp=00", {if3.inst_data_ok, if3.data_data_ok});
      end
   endtask

   task automatic test_reset_midflight();
      if3.data_req = 1'b1; if3.data_wr = 1'b0; if3.data_addr = 32'h0000_4000;
      #1;
      total++;
      if (if3.data_addr_ok !== 1'b1) begin
         bad++; $display("FAIL midflight_grant got=%b exp=1", if3.data_addr_ok);
      end
      tick();
      idle();
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1;
         total++;
         if ({if3.data_data_ok, if3.inst_data_ok} !== 2'b00) begin
            bad++; $display("FAIL midflight_no_resp cyc=%0d got=%b exp=00", k, {if3.data_data_ok, if3.inst_data_ok});
         end
         tick();
      end
   endtask

   initial begin
      total  = 0;
      bad    = 0;
      resetn = 1'b0;
      idle();
      if1.inst_addr = '0; if1.data_addr = '0; if1.data_wdata = '0; if1.mem_rdata = '0;
      if3.inst_addr = '0; if3.data_addr = '0; if3.data_wdata = '0; if3.mem_rdata = '0;
      test_reset();
      test_inst_read();
      test_data_write();
      test_starvation();
      test_pipeline();
      test_reset_midflight();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares one single-port synchronous SRAM between the instruction-fetch requester and the data requester of mycpu.
- Each requester uses a req/addr_ok/data_ok handshake.
- The arbiter grants at most one request per cycle and drives the shared memory port.
- It tracks the owner of each in-flight access so the response is returned to the correct requester after a fixed latency.

Parameters:
- MEM_LAT, 1, read latency of shared memory in cycles (legal 1..4); data_ok returns MEM_LAT cycles after grant.
- STARVE_MAX, 4, number of consecutive data grants made while inst_req is held before inst is forced to win.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  synchronous, active-low reset.
- inst_req  in  1  instruction-side request valid.
- inst_addr  in  32  instruction-side byte address.
- inst_addr_ok  out  1  instruction request accepted this cycle.
- inst_data_ok  out  1  instruction response valid.
- inst_rdata  out  32  instruction response data.
- data_req  in  1  data-side request valid.
- data_wr  in  1  1 = write, 0 = read.
- data_wstrb  in  4  byte enables for writes.
- data_addr  in  32  data-side byte address.
- data_wdata  in  32  write data.
- data_addr_ok  out  1  data request accepted this cycle.
- data_data_ok  out  1  data response valid; pulses for reads and writes.
- data_rdata  out  32  data response data.
- mem_en  out  1  shared memory access enable.
- mem_wen  out  4  shared memory byte write enables.
- mem_addr  out  32  shared memory address.
- mem_wdata  out  32  shared memory write data.
- mem_rdata  in  32  shared memory read data, valid MEM_LAT cycles after mem_en.

Behaviour:
- Reset (resetn=0 at a clk edge):
  - owner pipeline cleared (all slots invalid); starvation counter cleared.
  - addr_ok/data_ok/mem_en/mem_wen are 0 in the cycle after reset is sampled.
  - Accesses in flight at reset are dropped; no data_ok is issued for them.
- Grant is combinational from current req inputs and registered state; the grant fires in the same cycle as req.
- Default priority: data over inst.
  - Only data_req=1: grant data.
  - Only inst_req=1: grant inst.
  - Both high: grant data unless starve_cnt == STARVE_MAX, in which case grant inst.
- Starvation counter starve_cnt (width clog2(STARVE_MAX+1)):
  - increments on each cycle with data grant AND inst_req=1.
  - clears on any inst grant or any cycle with inst_req=0.
  - saturates at STARVE_MAX.
- Grant outputs:
  - inst_addr_ok = inst grant; data_addr_ok = data grant. Never both 1.
  - mem_en = any grant.
  - mem_addr = granted requester's address.
  - mem_wen = data_wstrb when data grant and data_wr=1, else 4'b0000.
  - mem_wdata = data_wdata.
  - When no grant: mem_en=0, mem_wen=0.
- Owner pipeline: MEM_LAT-deep shift register of {valid, is_data}.
  - Stage 0 is loaded on each clk edge with {any grant, data grant}.
  - Last stage is the response slot.
- Response outputs:
  - inst_data_ok = last.valid & ~last.is_data.
  - data_data_ok = last.valid & last.is_data.
  - inst_rdata = data_rdata = mem_rdata, qualified by the respective data_ok; value is don't-care otherwise.
- Throughput: back-to-back grants every cycle; responses return in grant order, one per cycle; no back-pressure on responses.
- Requester rules:
  - A requester holds req and its fields stable until addr_ok.
  - A requester may drop req without addr_ok; no state change results.
- Simultaneous events: a response returning and a new grant in the same cycle are independent; both occur.
- Write responses: data_data_ok pulses MEM_LAT cycles after a write grant; data_rdata is don't-care.

Test Plan:
- Reset check: resetn=0 for 2 cycles with inst_req=data_req=1 → all outputs 0 in the cycle after reset is sampled; the first inst_addr_ok/data_addr_ok appears only in the first cycle with resetn=1.
- Single inst read, MEM_LAT=1: inst_req at addr 0x1c000000, mem_rdata=0x02800c0c next cycle → inst_addr_ok=1 and mem_en=1 with mem_wen=0 in cycle 0; inst_data_ok=1 with inst_rdata=0x02800c0c in cycle 1.
- Data write: data_req with wr=1, wstrb=4'b0011, addr 0x1000, wdata 0xdeadbeef → mem_wen=4'b0011, mem_addr=0x1000, mem_wdata=0xdeadbeef in the grant cycle; data_data_ok=1 MEM_LAT cycles later; inst_data_ok stays 0.
- Contention/starvation, STARVE_MAX=4: inst_req and data_req held high continuously → grant sequence D,D,D,D,I,D,D,D,D,I,…; no cycle with both addr_ok high.
- Pipelined ordering, MEM_LAT=3: grants I,D,I on consecutive cycles → data_ok order inst,data,inst on cycles 3,4,5; each rdata matches mem_rdata in that cycle.
- Reset mid-flight: grant data read, assert resetn=0 one cycle later → no data_data_ok ever issued for that access.
